// File: rtl/xnor_conv_sched_if.sv
// rtl/xnor_conv_sched_if.sv - fetch, helper and result bus of the XNOR convolution scheduler
//
// Purpose: bundles the three point-to-point links the scheduler owns.
//   win_req_*  : window fetch request (valid/ready) with output row/col and channel
//   win_rsp_*  : fetched activation and weight windows (valid only, no backpressure)
//   hlp_*      : operands to, and signed score from, the external XNOR/popcount helper
//   out_*      : accumulated per-position result (valid/ready) with its row/col
// Modports: master = scheduler side, slave = fetch unit / helper / consumer side.
// Index fields are at least one bit wide so a 1x1 tile or single channel still
// has a legal port.

interface xnor_conv_sched_if #(
    parameter int C_IN  = 4,
    parameter int OUT_W = 8,
    parameter int OUT_H = 8,
    parameter int ACC_W = 10
);
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int CH_W  = (C_IN  > 1) ? $clog2(C_IN)  : 1;

    logic                    win_req_valid;
    logic                    win_req_ready;
    logic [ROW_W-1:0]        win_req_row;
    logic [COL_W-1:0]        win_req_col;
    logic [CH_W-1:0]         win_req_ch;

    logic                    win_rsp_valid;
    logic [24:0]             win_rsp_act;
    logic [24:0]             win_rsp_wgt;

    logic [24:0]             hlp_a;
    logic [24:0]             hlp_b;
    logic signed [5:0]       hlp_c;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [ROW_W-1:0]        out_row;
    logic [COL_W-1:0]        out_col;

    modport master (
        output win_req_valid, win_req_row, win_req_col, win_req_ch,
        input  win_req_ready,
        input  win_rsp_valid, win_rsp_act, win_rsp_wgt,
        output hlp_a, hlp_b,
        input  hlp_c,
        output out_valid, out_data, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  win_req_valid, win_req_row, win_req_col, win_req_ch,
        output win_req_ready,
        output win_rsp_valid, win_rsp_act, win_rsp_wgt,
        input  hlp_a, hlp_b,
        output hlp_c,
        input  out_valid, out_data, out_row, out_col,
        output out_ready
    );
endinterface

// File: rtl/xnor_conv_sched.sv
// rtl/xnor_conv_sched.sv - sequencing controller for the 5x5 binary XNOR/popcount convolution
//
// Purpose: walks every output position of one tile in row-major order; for each
// position fetches one activation/weight window pair per input channel, feeds the
// pair to the external XNOR helper, accumulates the signed helper scores and
// presents one signed sum per position on the result port.
//
// Ports:
//   i_clock  : single clock, rising edge
//   i_reset  : synchronous, active-high; aborts a tile immediately (no done pulse)
//   i_start  : one-cycle pulse, begins a tile when idle, ignored while busy
//   o_busy   : high from the cycle after an accepted start until done
//   o_done   : one-cycle pulse, the cycle after the last result handshake
//   io_bus   : fetch request/response, helper operands/score and result port
//
// Per channel the walk costs REQ, WAIT, ACC (3 cycles minimum); each position
// adds one EMIT cycle, so a stall-free position takes 3*C_IN+1 cycles.

module xnor_conv_sched #(
    parameter int C_IN  = 4,
    parameter int OUT_W = 8,
    parameter int OUT_H = 8,
    parameter int ACC_W = 10
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    xnor_conv_sched_if.master      io_bus
);
    localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int CH_W  = (C_IN  > 1) ? $clog2(C_IN)  : 1;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_H - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_W - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(C_IN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_ACC  = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [CH_W-1:0]         r_ch;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out_data;
    logic [24:0]             r_hlp_a;
    logic [24:0]             r_hlp_b;
    logic                    r_done;

    logic                    w_req_valid;
    logic                    w_out_valid;
    logic                    w_busy;
    logic                    w_last_ch;
    logic                    w_last_col;
    logic                    w_last_pos;
    logic signed [ACC_W-1:0] w_hlp_c_ext;
    logic signed [ACC_W-1:0] w_acc_sum;

    assign w_last_ch   = (r_ch == LAST_CH);
    assign w_last_col  = (r_col == LAST_COL);
    assign w_last_pos  = (r_row == LAST_ROW) && w_last_col;

    // Helper score is 6-bit signed; widen by sign replication before the add.
    assign w_hlp_c_ext = {{(ACC_W-6){io_bus.hlp_c[5]}}, io_bus.hlp_c};
    assign w_acc_sum   = r_acc + w_hlp_c_ext;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                if (io_bus.win_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only WAIT looks at the response, so a response coinciding
                // with the request handshake is never captured.
                if (io_bus.win_rsp_valid) begin
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                w_state_nxt = w_last_ch ? S_EMIT : S_REQ;
            end
            S_EMIT: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_nxt = w_last_pos ? S_IDLE : S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy      = 1'b0;
            end
        endcase
    end

    // Position counters, accumulator, helper operands and result register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_ch       <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_hlp_a    <= '0;
            r_hlp_b    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row <= '0;
                        r_col <= '0;
                        r_ch  <= '0;
                        r_acc <= '0;
                    end
                end
                S_WAIT: begin
                    if (io_bus.win_rsp_valid) begin
                        r_hlp_a <= io_bus.win_rsp_act;
                        r_hlp_b <= io_bus.win_rsp_wgt;
                    end
                end
                S_ACC: begin
                    r_acc <= w_acc_sum;
                    if (w_last_ch) begin
                        // Result taken from the adder so the last channel's
                        // score is included without an extra cycle.
                        r_out_data <= w_acc_sum;
                        r_ch       <= '0;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (io_bus.out_ready) begin
                        r_acc <= '0;
                        if (w_last_pos) begin
                            r_row  <= '0;
                            r_col  <= '0;
                            r_done <= 1'b1;
                        end else if (w_last_col) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.win_req_valid = w_req_valid;
    assign io_bus.win_req_row   = r_row;
    assign io_bus.win_req_col   = r_col;
    assign io_bus.win_req_ch    = r_ch;
    assign io_bus.hlp_a         = r_hlp_a;
    assign io_bus.hlp_b         = r_hlp_b;
    assign io_bus.out_valid     = w_out_valid;
    assign io_bus.out_data      = r_out_data;
    assign io_bus.out_row       = r_row;
    assign io_bus.out_col       = r_col;
    assign o_busy               = w_busy;
    assign o_done               = r_done;

endmodule

// File: doc/xnor_conv_sched.md
Name: xnor_conv_sched

Overview:
- Sequencing controller for the 5x5 binary XNOR/popcount convolution datapath.
- Walks every output position of one feature-map tile in row-major order. For each position it fetches one 25-bit activation window and one 25-bit weight window per input channel over a request/response interface.
- Drives the external XNOR helper (25-bit operands, signed 6-bit result), accumulates the per-channel results, and emits one signed sum per output position through a valid/ready port.

Parameters:
- C_IN, 4, input channels accumulated per output position (>=1)
- OUT_W, 8, output columns per tile (>=1)
- OUT_H, 8, output rows per tile (>=1)
- ACC_W, 10, accumulator/output width, signed; must satisfy 2^(ACC_W-1) > 25*C_IN

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a tile when idle
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse after the last output handshake
- win_req_valid  out  1  window fetch request
- win_req_ready  in  1  fetch unit accepts request
- win_req_row  out  $clog2(OUT_H)  output row of request
- win_req_col  out  $clog2(OUT_W)  output column of request
- win_req_ch  out  $clog2(C_IN) (min 1)  channel of request
- win_rsp_valid  in  1  window/weight data valid
- win_rsp_act  in  25  activation window bits
- win_rsp_wgt  in  25  weight window bits
- hlp_a  out  25  registered activation operand to XNOR helper
- hlp_b  out  25  registered weight operand to XNOR helper
- hlp_c  in  6 signed  helper result, 2*popcount(XNOR) - 25, range -25..+25
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W signed  accumulated sum over C_IN channels
- out_row  out  $clog2(OUT_H)  row of out_data
- out_col  out  $clog2(OUT_W)  column of out_data

Behaviour:
- Reset: state IDLE; row/col/ch/acc = 0; busy, done, win_req_valid and out_valid = 0; hlp_a, hlp_b, out_data = 0. Reset asserted mid-tile aborts immediately: no done pulse, and any pending request or output is dropped.
- FSM states and transitions:
  - IDLE: start=1 -> REQ with row=col=ch=0, acc=0, busy=1. start=0 stays IDLE.
  - REQ: win_req_valid=1 with row/col/ch held stable. Request fires when win_req_ready=1 -> WAIT.
  - WAIT: on win_rsp_valid=1, latch hlp_a<=win_rsp_act and hlp_b<=win_rsp_wgt -> ACC.
  - ACC (one cycle): acc <= acc + sign-extended hlp_c.
    - If ch < C_IN-1: ch++ -> REQ.
    - Else: out_data <= acc + hlp_c, ch <= 0 -> EMIT.
  - EMIT: out_valid=1; out_data/out_row/out_col held stable until out_ready=1. On the handshake, acc <= 0, then:
    - Not last position: advance col; at col wrap to 0, row++ -> REQ.
    - Last position (row=OUT_H-1, col=OUT_W-1): done=1 for one cycle, busy=0, row=col=0 -> IDLE.
- Ignored inputs:
  - start while busy is ignored.
  - win_rsp_valid outside WAIT is ignored.
  - A response arriving in the same cycle as the request handshake is not captured; the response is sampled from the first WAIT cycle.
- Minimum per-channel latency: 3 cycles (REQ, WAIT, ACC), giving a minimum of 3*C_IN+1 cycles per output position with zero stalls.
- Arithmetic: every addition is signed in ACC_W bits. Overflow cannot occur under the ACC_W constraint.
- hlp_a/hlp_b keep their last latched value outside WAIT/ACC. hlp_c is only sampled in ACC.
- done and the final out handshake never coincide: done follows the handshake by one cycle.

Test Plan:
- Fetch model returns act == wgt on all channels (hlp_c = +25), C_IN=4 -> every out_data = +100; 64 outputs in order (0,0),(0,1)...(7,7); done pulses exactly once, one cycle after the last handshake.
- Fetch model returns act = ~wgt on all channels (hlp_c = -25) -> every out_data = -100. Channel pattern +25, -25, +3, -7 -> out_data = -4.
- Hold out_ready=0 for 5 cycles at position (2,3) -> out_valid stays 1 with out_data/out_row/out_col stable; no new win_req_valid is issued until the handshake.
- win_req_ready low for 4 cycles, then rsp delayed 3 cycles, plus a spurious win_rsp_valid while in REQ -> request fields stable throughout, spurious response ignored, results unchanged from the zero-stall run.
- Pulse start while busy, mid-tile -> no restart. Assert reset during EMIT of position (4,5) -> next cycle out_valid=0, busy=0, no done pulse; a new start runs the full tile from (0,0).
- Minimal configuration OUT_W=OUT_H=C_IN=1 -> one request with ch=0, one output, done on the following cycle; zero-stall start-to-done = 5 cycles.
